// File: rtl/mcd212_bus_master.sv
// mcd212_bus_master: turns a valid/ready request stream into MCD212 bus cycles with wait states and timeout
module mcd212_bus_master #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int GAP_CYCLES     = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [21:0] i_req_addr,
   input  logic [1:0]  i_req_be,
   input  logic [15:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_rdata,
   output logic        o_rsp_error,
   output logic        o_busy,
   output logic        o_cs,
   output logic [21:0] o_address,
   output logic [15:0] o_din,
   output logic        o_uds,
   output logic        o_lds,
   output logic        o_write_strobe,
   input  logic        i_bus_ack,
   input  logic [15:0] i_dout
);
   typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;
   localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYCLES);
   localparam logic [1:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;
   localparam state_t     AFTER       = (GAP_CYCLES > 0) ? GAP : IDLE;
   logic        r_f_write [2];
   logic [21:0] r_f_addr  [2];
   logic [1:0]  r_f_be    [2];
   logic [15:0] r_f_wdata [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   state_t      r_state;
   logic [9:0]  r_wait;
   logic [1:0]  r_gap;
   logic        w_push;
   logic        w_pop;
   logic        w_head_write;
   logic [21:0] w_head_addr;
   logic [1:0]  w_head_be;
   logic [15:0] w_head_wdata;
   assign o_req_ready  = (r_count != 2'd2) && !i_reset;
   assign w_push       = i_req_valid && o_req_ready;
   assign w_pop        = (r_state == IDLE) && (r_count != 2'd0);
   assign o_busy       = (r_count != 2'd0) || (r_state != IDLE);
   assign w_head_write = r_f_write[r_rd_ptr];
   assign w_head_addr  = r_f_addr[r_rd_ptr];
   assign w_head_be    = r_f_be[r_rd_ptr];
   assign w_head_wdata = r_f_wdata[r_rd_ptr];
   // Request storage: the slot under the write pointer takes each accepted request
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_f_write[r_wr_ptr] <= i_req_write;
         r_f_addr[r_wr_ptr]  <= i_req_addr;
         r_f_be[r_wr_ptr]    <= i_req_be;
         r_f_wdata[r_wr_ptr] <= i_req_wdata;
      end
   end
   // FIFO pointers and occupancy; reset flushes everything queued
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end
   // Bus cycle sequencer with registered bus and response outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= IDLE;
         r_wait         <= 10'd0;
         r_gap          <= 2'd0;
         o_cs           <= 1'b0;
         o_address      <= 22'd0;
         o_din          <= 16'd0;
         o_uds          <= 1'b0;
         o_lds          <= 1'b0;
         o_write_strobe <= 1'b0;
         o_rsp_valid    <= 1'b0;
         o_rsp_rdata    <= 16'd0;
         o_rsp_error    <= 1'b0;
      end else begin
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= 16'd0;
         o_rsp_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  if (w_head_be == 2'b00) begin
                     o_rsp_valid <= 1'b1;
                     o_rsp_error <= 1'b1;
                  end else begin
                     o_cs           <= 1'b1;
                     o_address      <= w_head_addr;
                     o_uds          <= w_head_be[1];
                     o_lds          <= w_head_be[0];
                     o_write_strobe <= w_head_write;
                     o_din          <= w_head_write ? w_head_wdata : 16'd0;
                     r_wait         <= 10'd0;
                     r_state        <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (i_bus_ack || (r_wait == TIMEOUT_LIM)) begin
                  o_rsp_valid    <= 1'b1;
                  o_rsp_error    <= !i_bus_ack;
                  o_rsp_rdata    <= (i_bus_ack && !o_write_strobe) ? i_dout : 16'd0;
                  o_cs           <= 1'b0;
                  o_address      <= 22'd0;
                  o_din          <= 16'd0;
                  o_uds          <= 1'b0;
                  o_lds          <= 1'b0;
                  o_write_strobe <= 1'b0;
                  r_gap          <= GAP_LOAD;
                  r_state        <= AFTER;
               end else begin
                  r_wait <= r_wait + 10'd1;
               end
            end
            GAP: begin
               if (r_gap == 2'd0) r_state <= IDLE;
               else r_gap <= r_gap - 2'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mcd212_bus_master.sv
// tb_mcd212_bus_master: directed and random requests against a queue-based model of bus cycles and responses
module tb_mcd212_bus_master;
   localparam int T = 4;
   typedef struct packed {
      logic        w;
      logic [21:0] a;
      logic [1:0]  be;
      logic [15:0] d;
   } req_t;
   typedef struct packed {
      logic        err;
      logic [15:0] rd;
   } out_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [21:0] req_addr = '0;
   logic [1:0]  req_be = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;
   logic        cs;
   logic [21:0] address;
   logic [15:0] din;
   logic        uds;
   logic        lds;
   logic        write_strobe;
   logic        bus_ack = 1'b0;
   logic [15:0] dout = '0;
   int          checks = 0;
   int          errors = 0;
   req_t        acc_q[$];
   req_t        bus_q[$];
   out_t        out_q[$];
   req_t        cur;
   logic        prev_cs = 1'b0;
   logic        seen_pulse = 1'b0;
   logic        accepted = 1'b0;
   logic        rsp_seen = 1'b0;
   logic        last_err = 1'b0;
   logic [15:0] last_rdata = '0;
   logic [15:0] cur_dout = '0;
   logic        force_dout = 1'b0;
   int          fixed_wait = 0;
   int          wait_n = 0;
   int          cs_len = 0;
   int          low_len = 0;
   mcd212_bus_master #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(1)) dut (
      .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_write(req_write), .i_req_addr(req_addr), .i_req_be(req_be), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error), .o_busy(busy),
      .o_cs(cs), .o_address(address), .o_din(din), .o_uds(uds), .o_lds(lds),
      .o_write_strobe(write_strobe), .i_bus_ack(bus_ack), .i_dout(dout)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic req_t rand_req();
      req_t r;
      r.w  = 1'($urandom_range(0, 1));
      r.a  = 22'($urandom);
      r.be = 2'($urandom_range(0, 3));
      r.d  = 16'($urandom);
      return r;
   endfunction
   task automatic monitor();
      out_t o;
      req_t r;
      int   exp_len;
      if (cs && !prev_cs) begin
         if (seen_pulse) chk("gap_low_cycles", 32'(low_len >= 1), 1);
         chk("cs_has_request", 32'(bus_q.size() != 0), 1);
         cur      = (bus_q.size() != 0) ? bus_q[0] : '0;
         wait_n   = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 6);
         cur_dout = force_dout ? 16'h1234 : 16'($urandom);
         cs_len   = 0;
      end
      if (cs) begin
         cs_len++;
         chk("bus_addr", address, cur.a);
         chk("bus_strobes", {uds, lds, write_strobe}, {cur.be, cur.w});
         chk("bus_din", din, cur.w ? cur.d : 16'd0);
         chk("busy_in_access", busy, 1);
         bus_ack = (cs_len > wait_n);
         dout    = bus_ack ? cur_dout : 16'($urandom);
      end else begin
         bus_ack = 1'($urandom_range(0, 1));
         dout    = 16'($urandom);
         chk("idle_strobes", {uds, lds, write_strobe}, 0);
         if (prev_cs) begin
            exp_len = ((wait_n < T) ? wait_n : T) + 1;
            chk("cs_length", cs_len, exp_len);
            o.err = (wait_n > T);
            o.rd  = (o.err || cur.w) ? 16'd0 : cur_dout;
            out_q.push_back(o);
            if (bus_q.size() != 0) void'(bus_q.pop_front());
            chk("rsp_after_cs", rsp_valid, 1);
            low_len    = 0;
            seen_pulse = 1'b1;
         end
         low_len++;
      end
      if (rsp_valid) begin
         rsp_seen   = 1'b1;
         last_err   = rsp_error;
         last_rdata = rsp_rdata;
         chk("rsp_has_request", 32'(acc_q.size() != 0), 1);
         if (acc_q.size() != 0) begin
            r = acc_q.pop_front();
            if (r.be == 2'b00) begin
               o.err = 1'b1;
               o.rd  = 16'd0;
            end else begin
               chk("rsp_has_access", 32'(out_q.size() != 0), 1);
               o = (out_q.size() != 0) ? out_q.pop_front() : '0;
            end
            chk("rsp_error", rsp_error, o.err);
            chk("rsp_rdata", rsp_rdata, o.rd);
         end
      end
      prev_cs = cs;
   endtask
   task automatic cycle();
      req_t r;
      #1;
      accepted = req_valid && req_ready;
      if (accepted) begin
         r.w  = req_write;
         r.a  = req_addr;
         r.be = req_be;
         r.d  = req_wdata;
         acc_q.push_back(r);
         if (r.be != 2'b00) bus_q.push_back(r);
      end
      rsp_seen = 1'b0;
      @(negedge clk);
      monitor();
   endtask
   task automatic send(input logic w, input logic [21:0] a, input logic [1:0] be, input logic [15:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_be    = be;
      req_wdata = d;
      do begin
         cycle();
         n++;
      end while (!accepted && n < 100);
      req_valid = 1'b0;
      chk("send_accepted", accepted, 1);
   endtask
   task automatic wait_rsp(input string tag, input int exp_lat);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!rsp_seen && n < 40);
      chk(tag, n, exp_lat);
   endtask
   task automatic wait_idle(input int lim);
      int n = 0;
      while ((busy || acc_q.size() != 0) && n < lim) begin
         cycle();
         n++;
      end
      chk("drain_busy", busy, 0);
      chk("drain_rsp", acc_q.size(), 0);
   endtask
   task automatic chk_reset_vals();
      chk("rst_cs", cs, 0);
      chk("rst_strobes", {uds, lds, write_strobe}, 0);
      chk("rst_address", address, 0);
      chk("rst_din", din, 0);
      chk("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
      chk("rst_busy", busy, 0);
   endtask
   initial begin
      req_t pend;
      int   nacc;
      repeat (3) cycle();
      #1 chk("ready_in_reset", req_ready, 0);
      chk_reset_vals();
      reset = 1'b0;
      #1 chk("ready_after_reset", req_ready, 1);
      fixed_wait = 0;
      send(1'b1, 22'h000000, 2'b11, 16'h5AA5);
      wait_rsp("lat_zero_wait_write", 2);
      chk("t1_err", last_err, 0);
      wait_idle(20);
      fixed_wait = 1;
      force_dout = 1'b1;
      send(1'b0, 22'h000100, 2'b11, 16'h0);
      wait_rsp("lat_one_wait_read", 3);
      chk("t2_rdata", last_rdata, 16'h1234);
      chk("t2_err", last_err, 0);
      force_dout = 1'b0;
      wait_idle(20);
      fixed_wait = 0;
      send(1'b1, 22'h0000A1, 2'b10, 16'hA1A1);
      wait_rsp("lat_uds_write", 2);
      wait_idle(20);
      send(1'b1, 22'h0000A2, 2'b01, 16'hB2B2);
      wait_rsp("lat_lds_write", 2);
      wait_idle(20);
      send(1'b1, 22'h0000A3, 2'b00, 16'hC3C3);
      wait_rsp("lat_be_zero", 1);
      chk("be0_err", last_err, 1);
      wait_idle(20);
      fixed_wait = 100;
      send(1'b0, 22'h3FFFFF, 2'b11, 16'h0);
      wait_rsp("lat_timeout", 2 + T);
      chk("timeout_err", last_err, 1);
      chk("timeout_rdata", last_rdata, 0);
      wait_idle(20);
      fixed_wait = 0;
      send(1'b0, 22'h001234, 2'b11, 16'h0);
      wait_rsp("lat_after_timeout", 2);
      chk("after_timeout_err", last_err, 0);
      wait_idle(20);
      fixed_wait = 100;
      for (int k = 0; k < 3; k++) send(1'b0, 22'h10 + 22'(k), 2'b11, 16'h0);
      #1 chk("b2b_ready_full", req_ready, 0);
      send(1'b1, 22'h20, 2'b01, 16'h55AA);
      fixed_wait = 2;
      wait_idle(200);
      fixed_wait = 100;
      send(1'b0, 22'h3, 2'b11, 16'h0);
      send(1'b1, 22'h4, 2'b11, 16'hBEEF);
      chk("rst_mid_cs", cs, 1);
      reset = 1'b1;
      acc_q.delete();
      bus_q.delete();
      out_q.delete();
      prev_cs    = 1'b0;
      seen_pulse = 1'b0;
      #1 chk("ready_mid_reset", req_ready, 0);
      cycle();
      chk_reset_vals();
      reset = 1'b0;
      #1 chk("ready_after_mid_reset", req_ready, 1);
      repeat (8) cycle();
      chk("no_bus_after_reset", cs, 0);
      fixed_wait = 0;
      send(1'b1, 22'h2AAAAA, 2'b11, 16'h0F0F);
      wait_rsp("lat_after_reset", 2);
      wait_idle(20);
      fixed_wait = -1;
      nacc = 0;
      pend = rand_req();
      for (int c = 0; c < 3000 && nacc < 60; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_write = pend.w;
         req_addr  = pend.a;
         req_be    = pend.be;
         req_wdata = pend.d;
         cycle();
         if (accepted) begin
            nacc++;
            pend = rand_req();
         end
      end
      req_valid = 1'b0;
      chk("rand_accepted", nacc, 60);
      wait_idle(400);
      chk("bus_q_empty", bus_q.size(), 0);
      chk("out_q_empty", out_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
